// File: rtl/vga_pkg.sv
// Shared timing defaults, axis state encoding and counter width for the VGA raster generator.
package vga_pkg;

  localparam int CNT_W = 10;

  // 640x480@60 defaults
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  typedef enum logic [1:0] {
    AX_ACTIVE,
    AX_FRONT,
    AX_SYNC,
    AX_BACK
  } axis_state_t;

  function automatic int axis_total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping count plus ACTIVE/FRONT/SYNC/BACK region tracker.
// Region lengths are expected to be non-zero.
module vga_axis_counter
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W:0]   len_active,
  input  logic [CNT_W:0]   len_front,
  input  logic [CNT_W:0]   len_sync,
  input  logic [CNT_W:0]   len_back,
  output logic [CNT_W-1:0] count,
  output axis_state_t      state,
  output logic             wrap
);

  localparam int EW = CNT_W + 2;

  logic [EW-1:0] end_active, end_front, end_sync, end_total, cnt_p1;
  axis_state_t   state_nxt;

  // Region end boundaries (exclusive); a region's last count is end-1.
  assign end_active = EW'(len_active);
  assign end_front  = end_active + EW'(len_front);
  assign end_sync   = end_front + EW'(len_sync);
  assign end_total  = end_sync + EW'(len_back);
  assign cnt_p1     = EW'(count) + EW'(1);

  assign wrap = en && (cnt_p1 == end_total);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  count <= '0;
    else if (en) count <= wrap ? '0 : count + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= AX_ACTIVE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        AX_ACTIVE: if (cnt_p1 == end_active) state_nxt = AX_FRONT;
        AX_FRONT:  if (cnt_p1 == end_front)  state_nxt = AX_SYNC;
        AX_SYNC:   if (cnt_p1 == end_sync)   state_nxt = AX_BACK;
        AX_BACK:   if (cnt_p1 == end_total)  state_nxt = AX_ACTIVE;
        default:   state_nxt = AX_ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered sync, display enable, coordinates and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_cnt is 0.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int LW      = CNT_W + 1;

  generate
    if (H_TOTAL > (1 << CNT_W)) begin : g_h_too_long
      $error("vga_timing_gen: H_TOTAL %0d exceeds counter range", H_TOTAL);
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_v_too_long
      $error("vga_timing_gen: V_TOTAL %0d exceeds counter range", V_TOTAL);
    end
  endgenerate

  logic [CNT_W-1:0] h, v;
  axis_state_t      h_state, v_state;
  logic             h_wrap, v_wrap_unused;
  logic             active, at_line, at_frame;

  vga_axis_counter u_h (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (pix_en),
    .len_active (LW'(H_ACTIVE)),
    .len_front  (LW'(H_FRONT)),
    .len_sync   (LW'(H_SYNC)),
    .len_back   (LW'(H_BACK)),
    .count      (h),
    .state      (h_state),
    .wrap       (h_wrap)
  );

  // Vertical axis steps only on the pixel that closes a line.
  vga_axis_counter u_v (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (h_wrap),
    .len_active (LW'(V_ACTIVE)),
    .len_front  (LW'(V_FRONT)),
    .len_sync   (LW'(V_SYNC)),
    .len_back   (LW'(V_BACK)),
    .count      (v),
    .state      (v_state),
    .wrap       (v_wrap_unused)
  );

  assign active   = (h_state == AX_ACTIVE) && (v_state == AX_ACTIVE);
  assign at_line  = (h == '0);
  assign at_frame = at_line && (v == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= !HSYNC_POL;
      vsync       <= !VSYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hsync       <= (h_state == AX_SYNC) ? HSYNC_POL : !HSYNC_POL;
      vsync       <= (v_state == AX_SYNC) ? VSYNC_POL : !VSYNC_POL;
      de          <= active;
      x           <= active ? h : '0;
      y           <= active ? v : '0;
      line_start  <= at_line;
      frame_start <= at_frame;
    end else begin
      // Levels hold while the pixel enable is low; strobes never stretch.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fcnt_q;

  // Steps on the same edge that raises frame_start, so both appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  fcnt_q <= '0;
    else if (pix_en && at_frame) fcnt_q <= fcnt_q + 8'd1;
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator feeding the VGA colour/output stage on iCEBreaker. Runs horizontal and vertical axis counters gated by a pixel-rate enable, and produces registered sync, display-enable, pixel coordinates and frame/line strobes. The downstream colour logic consumes `de`, `x` and `y` and forwards them to `red`, `green` and `blue`. This block owns all porch and sync arithmetic.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch, pixels
- `H_SYNC`, 96, horizontal sync width, pixels
- `H_BACK`, 48, horizontal back porch, pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch, lines
- `V_SYNC`, 2, vertical sync width, lines
- `V_BACK`, 33, vertical back porch, lines
- `HSYNC_POL`, 0, asserted level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0, asserted level of `vsync` (0 = active-low)
- `CLK`  in  1  system clock (12 MHz board clock, or PLL output)
- `RST_N`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  pixel-rate enable; counters advance only when high
- `hsync`  out  1  horizontal sync, registered
- `vsync`  out  1  vertical sync, registered
- `de`  out  1  display enable; high only in the active region
- `x`  out  10  horizontal pixel index; valid when `de` is high
- `y`  out  10  vertical line index; valid when `de` is high
- `line_start`  out  1  one-`CLK` strobe at h=0 of every line
- `frame_start`  out  1  one-`CLK` strobe at h=0, v=0
- `frame_cnt`  out  8  frame counter (see Configuration)

## Operation
- Horizontal counter `h` runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800 with defaults).
- Vertical counter `v` runs 0..V_TOTAL-1 (525 with defaults).
- `v` increments only on a `pix_en` cycle where `h` wraps from H_TOTAL-1 to 0.
- `v` wraps from V_TOTAL-1 to 0.
- Each axis has a state machine: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - The transition is taken when the axis count reaches the last value of the current region.
  - ACTIVE covers counts [0, ACTIVE); FRONT [ACTIVE, ACTIVE+FRONT); SYNC the next SYNC counts; BACK the rest.
- `hsync` equals `HSYNC_POL` in H state SYNC, else its inverse. `vsync` follows the same rule with V state SYNC and `VSYNC_POL`.
- `de` = (H state ACTIVE) AND (V state ACTIVE).
- `x` = `h` and `y` = `v` when `de` is high. Both hold 0 when `de` is low.
- `line_start` pulses for exactly one `CLK` cycle, in the same cycle that `h` = 0 is presented on the outputs. `frame_start` additionally requires `v` = 0.
- `pix_en` low freezes every counter, state and level output. Strobes are forced to 0 during such cycles.
- All arithmetic is unsigned. Counters are 10 bits.
- Any parameter set with H_TOTAL > 1024 or V_TOTAL > 1024 is illegal. Elaboration fails with `$error`.

## Timing
- Reset values:
  - `hsync` = ~HSYNC_POL, `vsync` = ~VSYNC_POL
  - `de` = 0, `x` = 0, `y` = 0
  - `line_start` = 0, `frame_start` = 0, `frame_cnt` = 0
  - Counters 0; both states ACTIVE.
- Outputs are registered and lag the counters by one `pix_en` cycle.
- The first `pix_en` cycle after `RST_N` deasserts presents h=0, v=0:
  - `de` = 1, `line_start` = 1, `frame_start` = 1.
- With `pix_en` held high, one frame is H_TOTAL*V_TOTAL = 420000 cycles.
- Reset asserted mid-frame clears everything asynchronously. Timing restarts at h=0, v=0. No partial strobe is emitted.
- On a cycle where `h` and `v` wrap simultaneously, the next output cycle shows `frame_start` = 1 and `line_start` = 1 together.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt` increments by 1 on every `frame_start`, wrapping 255 → 0.
  - It is intended for downstream colour cycling.
- Not defined: `frame_cnt` is tied to 0 and no counter register is synthesised.

## Structure
- Shared package `vga_pkg` holds:
  - default timing constants for 640x480@60
  - the axis state enum (`AX_ACTIVE`, `AX_FRONT`, `AX_SYNC`, `AX_BACK`)
  - the counter width constant (10)
- Sub-module `vga_axis_counter` is instantiated twice (horizontal and vertical). Each instance provides:
  - count, state and wrap-out, with ports for ACTIVE, FRONT, SYNC and BACK lengths.
  - The horizontal wrap-out drives the vertical instance's enable.

## Test plan
- Reset, then `pix_en` = 1 → first output cycle: `de` = 1, `x` = 0, `y` = 0, `frame_start` = 1, `hsync` = 1, `vsync` = 1.
- Free-run one line → `de` falls after x = 639. `hsync` is low for exactly 96 cycles, starting at h = 656. `line_start` recurs every 800 cycles.
- Free-run one frame → `vsync` is low on lines 490–491 only. `frame_start` recurs every 420000 cycles. `de` is never high with y ≥ 480.
- `pix_en` toggling 1/0 → all outputs hold during low cycles. The line period doubles to 1600 `CLK` cycles, and strobes are 1 `CLK` wide.
- Assert `RST_N` at h = 300, v = 200 → outputs take reset values immediately. After release, the first output cycle is h = 0, v = 0 with `frame_start` = 1.
- With `VGA_TIMING_FRAME_CNT_EN` defined, run 257 frames → `frame_cnt` shows 255 → 0 wrap. Without the macro, `frame_cnt` stays 0 throughout.
